// File: rtl/hardwired_control_unit.sv
// hardwired_control_unit
//   Hardwired control sequencer for the bus-based datapath. Steps through
//   fetch (T0-T2) and execute (T3-T6), stalls in T1 until memory is ready,
//   and parks in HALTED on a halt instruction or a Stop request in T0.
//
// Ports
//   Clock, Clear        : rising-edge clock, asynchronous active-high reset
//   IR[31:0]            : opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15]
//   MemReady            : memory data valid this cycle
//   Stop                : halt request, honoured only in T0
//   Run                 : 1 while sequencing (T0-T6)
//   PCout, Zlowout, ZHighout, MDRout            : bus drive enables
//   MARin, PCin, MDRin, IRin, Yin, ZLowIn,
//   ZHighIn, HIin, LOin                         : register load enables
//   IncPC, Read         : ALU increment, memory read
//   ALU_op[4:0]         : ALU operation (non-zero only in T4)
//   Rin/Rout[NUM_REGS-1:0] : one-hot general register load/drive
//
// state  | meaning
// RST    | held in reset, all outputs 0
// T0     | PC -> MAR, PC+1 -> Z
// T1     | Z -> PC, memory read into MDR (stalls until MemReady)
// T2     | MDR -> IR, dispatch on opcode
// T3     | first operand -> Y
// T4     | second operand through ALU -> Z
// T5     | Z low -> Ra or LO
// T6     | Z high -> HI (mul/div only)
// HALTED | stopped, all outputs 0, left only via Clear

module hardwired_control_unit #(
   parameter int NUM_REGS = 16,
   parameter int SEL_W    = 4
) (
   input  logic                Clock,
   input  logic                Clear,
   input  logic [31:0]         IR,
   input  logic                MemReady,
   input  logic                Stop,
   output logic                Run,
   output logic                PCout,
   output logic                Zlowout,
   output logic                ZHighout,
   output logic                MDRout,
   output logic                MARin,
   output logic                PCin,
   output logic                MDRin,
   output logic                IRin,
   output logic                Yin,
   output logic                ZLowIn,
   output logic                ZHighIn,
   output logic                HIin,
   output logic                LOin,
   output logic                IncPC,
   output logic                Read,
   output logic [4:0]          ALU_op,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout
);

   typedef enum logic [3:0] {
      RST, T0, T1, T2, T3, T4, T5, T6, HALTED
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t state, next_state;

   logic [4:0]       opcode;
   logic [SEL_W-1:0] ra, rb, rc;
   logic             is_alu3, is_muldiv, is_halt;
   logic             unused_ir;

   assign opcode    = IR[31:27];
   assign ra        = IR[26 -: SEL_W];
   assign rb        = IR[22 -: SEL_W];
   assign rc        = IR[18 -: SEL_W];
   assign unused_ir = ^IR[14:0];

   // add..or occupy one contiguous opcode range
   assign is_alu3   = (opcode >= OP_ADD) && (opcode <= OP_OR);
   assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign is_halt   = (opcode == OP_HALT);

   // field values beyond NUM_REGS select nothing, so the bus stays one-hot or idle
   function automatic logic [NUM_REGS-1:0] sel_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_REGS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         v[i] = ({{(32-SEL_W){1'b0}}, sel} == 32'(i));
      end
      return v;
   endfunction

   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) state <= RST;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      Run      = 1'b0;
      PCout    = 1'b0;
      Zlowout  = 1'b0;
      ZHighout = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      ZLowIn   = 1'b0;
      ZHighIn  = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      ALU_op   = 5'b0;
      Rin      = '0;
      Rout     = '0;

      case (state)
         RST: next_state = T0;
         T0: begin
            Run    = 1'b1;
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            ZLowIn = 1'b1;
            next_state = Stop ? HALTED : T1;
         end
         T1: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            // PC loads only in the cycle that also leaves T1, so it loads once
            if (MemReady) begin
               PCin       = 1'b1;
               next_state = T2;
            end
         end
         T2: begin
            Run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
            if (is_alu3 || is_muldiv) next_state = T3;
            else if (is_halt)         next_state = HALTED;
            else                      next_state = T0;
         end
         T3: begin
            Run  = 1'b1;
            Yin  = 1'b1;
            Rout = is_muldiv ? sel_decode(ra) : sel_decode(rb);
            next_state = T4;
         end
         T4: begin
            Run     = 1'b1;
            Rout    = is_muldiv ? sel_decode(rb) : sel_decode(rc);
            ALU_op  = opcode;
            ZLowIn  = 1'b1;
            ZHighIn = is_muldiv;
            next_state = T5;
         end
         T5: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            if (is_muldiv) begin
               LOin       = 1'b1;
               next_state = T6;
            end else begin
               Rin        = sel_decode(ra);
               next_state = T0;
            end
         end
         T6: begin
            Run      = 1'b1;
            ZHighout = 1'b1;
            HIin     = 1'b1;
            next_state = T0;
         end
         HALTED: next_state = HALTED;
         default: next_state = RST;
      endcase
   end

endmodule

// File: tb/tb_hardwired_control_unit.sv
module tb_hardwired_control_unit;

   typedef logic [52:0] vec_t;

   localparam vec_t B_RUN      = vec_t'(1) << 52;
   localparam vec_t B_PCOUT    = vec_t'(1) << 51;
   localparam vec_t B_ZLOWOUT  = vec_t'(1) << 50;
   localparam vec_t B_ZHIGHOUT = vec_t'(1) << 49;
   localparam vec_t B_MDROUT   = vec_t'(1) << 48;
   localparam vec_t B_MARIN    = vec_t'(1) << 47;
   localparam vec_t B_PCIN     = vec_t'(1) << 46;
   localparam vec_t B_MDRIN    = vec_t'(1) << 45;
   localparam vec_t B_IRIN     = vec_t'(1) << 44;
   localparam vec_t B_YIN      = vec_t'(1) << 43;
   localparam vec_t B_ZLOWIN   = vec_t'(1) << 42;
   localparam vec_t B_ZHIGHIN  = vec_t'(1) << 41;
   localparam vec_t B_HIIN     = vec_t'(1) << 40;
   localparam vec_t B_LOIN     = vec_t'(1) << 39;
   localparam vec_t B_INCPC    = vec_t'(1) << 38;
   localparam vec_t B_READ     = vec_t'(1) << 37;

   localparam vec_t E_ZERO = '0;
   localparam vec_t E_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
   localparam vec_t E_T1   = B_RUN | B_ZLOWOUT | B_READ | B_MDRIN;
   localparam vec_t E_T1R  = E_T1 | B_PCIN;
   localparam vec_t E_T2   = B_RUN | B_MDROUT | B_IRIN;

   function automatic vec_t f_alu(input logic [4:0] op);
      return vec_t'(op) << 32;
   endfunction
   function automatic vec_t f_rin(input logic [15:0] v);
      return vec_t'(v) << 16;
   endfunction
   function automatic vec_t f_rout(input logic [15:0] v);
      return vec_t'(v);
   endfunction

   logic        Clock = 1'b0;
   logic        Clear;
   logic [31:0] IR;
   logic        MemReady;
   logic        Stop;
   logic        Run, PCout, Zlowout, ZHighout, MDRout;
   logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
   logic        IncPC, Read;
   logic [4:0]  ALU_op;
   logic [15:0] Rin, Rout;
   vec_t        obs;

   int checks = 0;
   int errors = 0;
   vec_t exp_q[$];

   hardwired_control_unit #(.NUM_REGS(16), .SEL_W(4)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady), .Stop(Stop),
      .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
      .IncPC(IncPC), .Read(Read), .ALU_op(ALU_op), .Rin(Rin), .Rout(Rout)
   );

   always #5 Clock = ~Clock;

   assign obs = {Run, PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
                 Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, ALU_op, Rin, Rout};

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      vec_t e;
      Clear = 1'b1; IR = 32'h0; MemReady = 1'b1; Stop = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(E_ZERO);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: got %h required %h", i, obs, e);
         end
      end
      Clear = 1'b0;
      exp_q.push_back(E_ZERO);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_rst_state: got %h required %h", obs, e);
      end
   endtask

   // starts in RST, ends with T0 observed
   task automatic test_and();
      vec_t e;
      IR = 32'h4A920000;
      MemReady = 1'b1;
      exp_q.push_back(E_T0);
      exp_q.push_back(E_T1R);
      exp_q.push_back(E_T2);
      exp_q.push_back(B_RUN | B_YIN | f_rout(16'h0004));
      exp_q.push_back(B_RUN | f_rout(16'h0010) | f_alu(5'b01001) | B_ZLOWIN);
      exp_q.push_back(B_RUN | B_ZLOWOUT | f_rin(16'h0020));
      exp_q.push_back(E_T0);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL and_seq cyc %0d: got %h required %h", i, obs, e);
         end
      end
   endtask

   task automatic test_mul();
      vec_t e;
      IR = 32'h71100000;
      exp_q.push_back(E_T1R);
      exp_q.push_back(E_T2);
      exp_q.push_back(B_RUN | B_YIN | f_rout(16'h0004));
      exp_q.push_back(B_RUN | f_rout(16'h0004) | f_alu(5'b01110) | B_ZLOWIN | B_ZHIGHIN);
      exp_q.push_back(B_RUN | B_ZLOWOUT | B_LOIN);
      exp_q.push_back(B_RUN | B_ZHIGHOUT | B_HIIN);
      exp_q.push_back(E_T0);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL mul_seq cyc %0d: got %h required %h", i, obs, e);
         end
      end
   endtask

   task automatic test_mem_stall();
      vec_t e;
      IR = 32'h4A920000;
      MemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(E_T1);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL stall_t1 cyc %0d: got %h required %h", i, obs, e);
         end
      end
      MemReady = 1'b1;
      exp_q.push_back(E_T1R);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL stall_release: got %h required %h", obs, e);
      end
      exp_q.push_back(E_T2);
      exp_q.push_back(B_RUN | B_YIN | f_rout(16'h0004));
      exp_q.push_back(B_RUN | f_rout(16'h0010) | f_alu(5'b01001) | B_ZLOWIN);
      exp_q.push_back(B_RUN | B_ZLOWOUT | f_rin(16'h0020));
      exp_q.push_back(E_T0);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL stall_tail cyc %0d: got %h required %h", i, obs, e);
         end
      end
   endtask

   // add R0,R15,R0: register 0 and the top register are both selectable
   task automatic test_reg_edges();
      vec_t e;
      IR = {5'b00011, 4'd0, 4'd15, 4'd0, 15'h0};
      exp_q.push_back(E_T1R);
      exp_q.push_back(E_T2);
      exp_q.push_back(B_RUN | B_YIN | f_rout(16'h8000));
      exp_q.push_back(B_RUN | f_rout(16'h0001) | f_alu(5'b00011) | B_ZLOWIN);
      exp_q.push_back(B_RUN | B_ZLOWOUT | f_rin(16'h0001));
      exp_q.push_back(E_T0);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reg_edges cyc %0d: got %h required %h", i, obs, e);
         end
      end
   endtask

   task automatic test_nop_undef();
      vec_t e;
      logic [31:0] irs [2];
      irs[0] = 32'hF8000000;
      irs[1] = 32'hD0000000;
      for (int k = 0; k < 2; k++) begin
         IR = irs[k];
         exp_q.push_back(E_T1R);
         exp_q.push_back(E_T2);
         exp_q.push_back(E_T0);
         for (int i = 0; exp_q.size() > 0; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL nop_undef ir %h cyc %0d: got %h required %h", IR, i, obs, e);
            end
         end
      end
   endtask

   // Stop held through T1..T5 must not halt; dropped before reaching T0
   task automatic test_stop_ignored();
      vec_t e;
      IR = 32'h4A920000;
      exp_q.push_back(E_T1R);
      exp_q.push_back(E_T2);
      exp_q.push_back(B_RUN | B_YIN | f_rout(16'h0004));
      exp_q.push_back(B_RUN | f_rout(16'h0010) | f_alu(5'b01001) | B_ZLOWIN);
      exp_q.push_back(B_RUN | B_ZLOWOUT | f_rin(16'h0020));
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         Stop = 1'b1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL stop_ignored cyc %0d: got %h required %h", i, obs, e);
         end
      end
      Stop = 1'b0;
      exp_q.push_back(E_T0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL stop_ignored_t0: got %h required %h", obs, e);
      end
   endtask

   task automatic test_stop();
      vec_t e;
      Stop = 1'b1;
      exp_q.push_back(E_T0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL stop_t0_strobes: got %h required %h", obs, e);
      end
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back(E_ZERO);
         tick();
         Stop = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL stop_halted cyc %0d: got %h required %h", i, obs, e);
         end
      end
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      exp_q.push_back(E_ZERO);
      exp_q.push_back(E_T0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL stop_clear_rst: got %h required %h", obs, e);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL stop_clear_t0: got %h required %h", obs, e);
      end
   endtask

   task automatic test_halt();
      vec_t e;
      IR = 32'hD8000000;
      exp_q.push_back(E_T1R);
      exp_q.push_back(E_T2);
      for (int i = 0; i < 5; i++) exp_q.push_back(E_ZERO);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL halt_seq cyc %0d: got %h required %h", i, obs, e);
         end
      end
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      exp_q.push_back(E_T0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL halt_clear_t0: got %h required %h", obs, e);
      end
   endtask

   task automatic test_clear_mid();
      vec_t e;
      IR = 32'h4A920000;
      exp_q.push_back(E_T1R);
      exp_q.push_back(E_T2);
      exp_q.push_back(B_RUN | B_YIN | f_rout(16'h0004));
      exp_q.push_back(B_RUN | f_rout(16'h0010) | f_alu(5'b01001) | B_ZLOWIN);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL clear_mid_pre cyc %0d: got %h required %h", i, obs, e);
         end
      end
      #2;
      Clear = 1'b1;
      exp_q.push_back(E_ZERO);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL clear_mid_async: got %h required %h", obs, e);
      end
      tick();
      Clear = 1'b0;
      exp_q.push_back(E_T0);
      exp_q.push_back(E_T1R);
      for (int i = 0; exp_q.size() > 0; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL clear_mid_restart cyc %0d: got %h required %h", i, obs, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_and();
      test_mul();
      test_mem_stall();
      test_reg_edges();
      test_nop_undef();
      test_stop_ignored();
      test_stop();
      test_halt();
      test_clear_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
